regmap_arbiter: RTL and testbench
=================================

# regmap_arbiter

Two-requester arbiter that shares the single access port of the configuration register map (NUMREGS 8-bit registers) between the UART command path (requester 0) and a second on-chip or test requester (requester 1). It accepts one transaction at a time with round-robin fairness and drives the register-map write/read strobes. It rejects out-of-range addresses, and returns one response per accepted request. It sits between the command decoders and the register map inside the digital core.

## Interface
- NUMREGS, 9, number of valid register addresses (0..NUMREGS-1)
- clk  input  1  core clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  request pending from requester 0/1
- req0_ready / req1_ready  output  1  request accepted this cycle (one-cycle pulse)
- req0_we / req1_we  input  1  1 = write, 0 = read
- req0_addr / req1_addr  input  8  register address
- req0_wdata / req1_wdata  input  8  write data
- rsp0_valid / rsp1_valid  output  1  response pulse to requester 0/1
- rsp_rdata  output  8  read data (shared, valid with rspN_valid)
- rsp_err  output  1  address out of range (shared, valid with rspN_valid)
- rm_we  output  1  register-map write strobe
- rm_re  output  1  register-map read strobe
- rm_addr  output  8  register-map address
- rm_wdata  output  8  register-map write data
- rm_rdata  input  8  register-map read data, valid the cycle after rm_re

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any reqN_valid, grant one requester; assert its reqN_ready combinationally that cycle; capture we/addr/wdata and grant id; go to ACCESS. Otherwise stay.
- Arbitration: only one valid → grant it. Both valid → grant the requester not granted last. The last_grant register resets to 1, so requester 0 wins the first tie.
- ACCESS: if the captured addr < NUMREGS, assert rm_we (write) or rm_re (read) for exactly one cycle with rm_addr/rm_wdata from the capture. If addr >= NUMREGS, assert no strobe and set err. Go to RESP.
- RESP: pulse rspN_valid for the granted requester for one cycle.
  - rsp_rdata = rm_rdata for a valid read, 0 for writes and errors.
  - rsp_err = err.
  - Update last_grant. Return to IDLE.
- No response backpressure; requesters must sample rspN_valid.
- A requester holds reqN_valid and its fields stable until reqN_ready. Fields changing before acceptance are ignored.
- Requests arriving in ACCESS/RESP wait; reqN_ready is never asserted outside IDLE.
- Back-to-back writes to the same address from both requesters are serialized in grant order. The last granted write persists.

## Timing
- Reset values: all outputs 0; state IDLE; last_grant = 1; capture registers 0.
- Reset asserted mid-transaction aborts immediately:
  - strobes and rsp pulses drop asynchronously;
  - no late strobe or response occurs after release;
  - the aborted requester sees no response.
- Latency, acceptance at cycle N (reqN_ready high):
  - rm_we/rm_re high at N+1;
  - rspN_valid high at N+2;
  - next acceptance possible at N+3.
- Peak throughput: one transaction per 3 cycles.
- rm_rdata is sampled in RESP (one cycle after rm_re) and driven onto rsp_rdata in that cycle.
- rm_addr/rm_wdata hold their captured values from N+1 until the next capture. They are don't-care when no strobe is asserted.
- Exactly one of rsp0_valid/rsp1_valid may be high in any cycle, and never both.

## Test plan
- Single write: req0 we=1 addr=3 wdata=0xA5 → req0_ready at N, rm_we with addr 3/data 0xA5 at N+1, rsp0_valid at N+2 with err=0, rdata=0.
- Read-back: req1 read addr=3 with rm_rdata returning 0xA5 → rm_re at N+1, rsp1_valid at N+2, rsp_rdata=0xA5.
- Tie after reset: both valid with continuous requests → grant order 0,1,0,1; each requester's responses in order; no cycle has both rsp pulses.
- Out of range: req0 addr=9 (NUMREGS=9) and addr=0xFF → no rm_we/rm_re, rsp0_valid with rsp_err=1, rdata=0.
- Reset mid-op: deassert reset_n in the ACCESS cycle → rm strobes drop immediately, no rsp pulse after release, next req0 is accepted from IDLE with last_grant=1.
- Hold stability: req1_valid held 5 cycles while a req0 transaction is in flight → req1_ready only in IDLE after rsp0_valid; req1's captured fields match the values at acceptance.

Source files
------------

// File: rtl/regmap_arbiter.sv
// regmap_arbiter
// Shares the single register-map access port between two requesters
// (0 = UART command path, 1 = on-chip/test requester). One transaction is
// in flight at a time. Ties are resolved round-robin. Out-of-range
// addresses are rejected with rsp_err. Each accepted request receives
// exactly one response.
//
// Ports
//   clk, reset_n               core clock, async active-low reset
//   reqN_valid/we/addr/wdata   request from requester N (held until reqN_ready)
//   reqN_ready                 one-cycle acceptance pulse (IDLE only)
//   rspN_valid                 one-cycle response pulse to requester N
//   rsp_rdata, rsp_err         shared response payload, valid with rspN_valid
//   rm_we, rm_re               register-map write / read strobes
//   rm_addr, rm_wdata          register-map address / write data
//   rm_rdata                   register-map read data, valid one cycle after rm_re
//
// state  | meaning
// IDLE   | waiting for a request; grants and captures one
// ACCESS | drives the rm_we/rm_re strobe (none if the address is out of range)
// RESP   | pulses rspN_valid to the granted requester, updates last_grant
module regmap_arbiter #(
  parameter int NUMREGS = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_we,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_we,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp0_valid,
  output logic       rsp1_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rm_we,
  output logic       rm_re,
  output logic [7:0] rm_addr,
  output logic [7:0] rm_wdata,
  input  logic [7:0] rm_rdata
);

  localparam logic [8:0] NUM_REGS_W = 9'(NUMREGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant;
  logic       cap_we;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;
  logic       cap_id;
  logic       err_q;

  logic       gnt0, gnt1;
  logic       in_range;

  // last_grant == 1 means requester 1 was served last, so 0 wins a tie.
  assign gnt0     = req0_valid && (!req1_valid || last_grant);
  assign gnt1     = req1_valid && (!req0_valid || !last_grant);
  assign in_range = ({1'b0, cap_addr} < NUM_REGS_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      cap_we     <= 1'b0;
      cap_addr   <= 8'h00;
      cap_wdata  <= 8'h00;
      cap_id     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt0) begin
            cap_we    <= req0_we;
            cap_addr  <= req0_addr;
            cap_wdata <= req0_wdata;
            cap_id    <= 1'b0;
          end else if (gnt1) begin
            cap_we    <= req1_we;
            cap_addr  <= req1_addr;
            cap_wdata <= req1_wdata;
            cap_id    <= 1'b1;
          end
        end
        ACCESS: err_q <= !in_range;
        RESP:   last_grant <= cap_id;
        default: ;
      endcase
    end
  end

  // Strobes and response pulses are decoded from state, so an async reset
  // (which forces IDLE) removes them immediately.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rm_we      = 1'b0;
    rm_re      = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 8'h00;
    rm_addr    = cap_addr;
    rm_wdata   = cap_wdata;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d    = ACCESS;
          req0_ready = gnt0;
          req1_ready = gnt1;
        end
      end
      ACCESS: begin
        rm_we   = cap_we && in_range;
        rm_re   = !cap_we && in_range;
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = !cap_id;
        rsp1_valid = cap_id;
        rsp_err    = err_q;
        rsp_rdata  = (!cap_we && !err_q) ? rm_rdata : 8'h00;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regmap_arbiter.sv
// Testbench for regmap_arbiter: directed steps plus randomized traffic,
// checked against a transaction-level model (register contents, round-robin
// last-grant bit, fixed 0/1/2-cycle response timeline).
module tb_regmap_arbiter;

  localparam int NUMREGS = 9;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_ready, req0_we;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rm_we, rm_re;
  logic [7:0] rm_addr, rm_wdata;
  logic [7:0] rm_rdata;

  regmap_arbiter #(.NUMREGS(NUMREGS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rm_we(rm_we), .rm_re(rm_re), .rm_addr(rm_addr), .rm_wdata(rm_wdata),
    .rm_rdata(rm_rdata)
  );

  always #5 clk = ~clk;

  // Register-map stub: write on rm_we, registered read data after rm_re,
  // garbage otherwise so a leaking rsp_rdata is visible.
  logic [7:0] stub_mem [256];
  always @(posedge clk) begin
    if (rm_we) stub_mem[rm_addr] <= rm_wdata;
    rm_rdata <= rm_re ? stub_mem[rm_addr] : 8'($urandom);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1)
      chk("rsp_exclusive", {31'b0, rsp0_valid & rsp1_valid}, 32'd0);
  end

  // Reference model
  logic [7:0] exp_mem [NUMREGS];
  bit         last_g;
  bit         pend [2];
  bit         t_we [2];
  logic [7:0] t_addr [2];
  logic [7:0] t_data [2];

  task automatic drive();
    req0_valid = pend[0]; req0_we = t_we[0]; req0_addr = t_addr[0]; req0_wdata = t_data[0];
    req1_valid = pend[1]; req1_we = t_we[1]; req1_addr = t_addr[1]; req1_wdata = t_data[1];
  endtask

  task automatic set_req(input int id, input bit we, input logic [7:0] a, input logic [7:0] d);
    pend[id] = 1'b1; t_we[id] = we; t_addr[id] = a; t_data[id] = d;
  endtask

  // Called just after a negedge. Serves all pending requests, checking the
  // whole accept/strobe/response timeline of each one.
  task automatic serve();
    int  w;
    bit  cw, ok;
    logic [7:0] ca, cd, er;
    while (pend[0] || pend[1]) begin
      drive();
      #1;
      if (pend[0] && pend[1]) w = last_g ? 0 : 1;
      else                    w = pend[0] ? 0 : 1;
      chk("req0_ready@accept", {31'b0, req0_ready}, {31'b0, w == 0});
      chk("req1_ready@accept", {31'b0, req1_ready}, {31'b0, w == 1});
      cw = t_we[w]; ca = t_addr[w]; cd = t_data[w];
      ok = (ca < NUMREGS);
      @(negedge clk);
      pend[w] = 1'b0;
      t_we[w] = 1'($urandom); t_addr[w] = 8'($urandom); t_data[w] = 8'($urandom);
      drive();
      #1;
      chk("rm_we@access", {31'b0, rm_we}, {31'b0, cw && ok});
      chk("rm_re@access", {31'b0, rm_re}, {31'b0, !cw && ok});
      if (ok) chk("rm_addr@access", {24'b0, rm_addr}, {24'b0, ca});
      if (ok && cw) chk("rm_wdata@access", {24'b0, rm_wdata}, {24'b0, cd});
      chk("ready_block@access", {30'b0, req1_ready, req0_ready}, 32'd0);
      er = (!cw && ok) ? exp_mem[ca] : 8'h00;
      if (cw && ok) exp_mem[ca] = cd;
      @(negedge clk);
      #1;
      chk("rsp0_valid@resp", {31'b0, rsp0_valid}, {31'b0, w == 0});
      chk("rsp1_valid@resp", {31'b0, rsp1_valid}, {31'b0, w == 1});
      chk("rsp_err@resp", {31'b0, rsp_err}, {31'b0, !ok});
      chk("rsp_rdata@resp", {24'b0, rsp_rdata}, {24'b0, er});
      chk("ready_block@resp", {30'b0, req1_ready, req0_ready}, 32'd0);
      chk("strobe_off@resp", {30'b0, rm_re, rm_we}, 32'd0);
      last_g = (w == 1);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) stub_mem[i] = 8'h00;
    for (int i = 0; i < NUMREGS; i++) exp_mem[i] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; t_we[i] = 1'b0; t_addr[i] = 8'h00; t_data[i] = 8'h00;
    end
    drive();
    reset_n = 1'b0;
    last_g  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    chk("reset_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("reset_strobes", {30'b0, rm_re, rm_we}, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("reset_rm_addr", {24'b0, rm_addr}, 32'd0);
    chk("reset_rm_wdata", {24'b0, rm_wdata}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Tie after reset: expect grant order 0,1,0,1.
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1'b1, 8'(k), 8'h10 + 8'(k));
      set_req(1, 1'b1, 8'(k + 4), 8'h20 + 8'(k));
      serve();
    end

    // Single write then read-back from the other requester.
    set_req(0, 1'b1, 8'd3, 8'hA5);
    serve();
    set_req(1, 1'b0, 8'd3, 8'h00);
    serve();

    // Out-of-range addresses.
    set_req(0, 1'b1, 8'd9, 8'h77);
    serve();
    set_req(0, 1'b0, 8'hFF, 8'h00);
    serve();

    // Reset in the ACCESS cycle of a req0 write.
    set_req(0, 1'b1, 8'd2, 8'h3C);
    drive();
    #1;
    chk("midrst_accept", {31'b0, req0_ready}, 32'd1);
    @(negedge clk);
    pend[0] = 1'b0;
    drive();
    #1;
    chk("midrst_rm_we_before", {31'b0, rm_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_strobes_drop", {30'b0, rm_re, rm_we}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last_g  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("midrst_no_late_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("midrst_no_late_strobe", {30'b0, rm_re, rm_we}, 32'd0);
      @(negedge clk);
    end
    // Tie straight after reset: req0 must win, and reg 2 was never written.
    set_req(0, 1'b0, 8'd2, 8'h00);
    set_req(1, 1'b1, 8'd2, 8'h5A);
    serve();
    set_req(0, 1'b0, 8'd2, 8'h00);
    serve();

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      for (int id = 0; id < 2; id++) begin
        if ($urandom_range(0, 2) != 0) begin
          logic [7:0] a;
          a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, NUMREGS + 1));
          set_req(id, 1'($urandom), a, 8'($urandom));
        end
      end
      serve();
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Final sweep: every register reads back the model's contents.
    for (int i = 0; i < NUMREGS; i++) begin
      set_req(i % 2, 1'b0, 8'(i), 8'h00);
      serve();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
